instr_cache: RTL and testbench
==============================

Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the IF-stage PC register and a word-wide backing instruction memory.
- Hits return the instruction combinationally in the same cycle, matching the IF-stage asynchronous fetch timing.
- Misses assert cpu_stall and refill a whole line over a valid/ready backing-memory handshake.
- cpu_stall ORs into the hazard unit's PCWrite/IF_ID_Write stall path.

Parameters:
- NUM_LINES, 64, number of lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_addr  input  ADDR_W  fetch byte address (pcF); bits [1:0] ignored.
- cpu_instr  output  32  fetched instruction; valid only when cpu_stall=0.
- cpu_stall  output  1  1 = fetch not satisfied; hold PC and IF/ID.
- invalidate  input  1  single-cycle pulse; clears all valid bits (fence.i).
- mem_req  output  1  refill request valid.
- mem_addr  output  ADDR_W  line-aligned refill base address.
- mem_ack  input  1  backing memory accepted the request.
- mem_rvalid  input  1  one refill beat present on mem_rdata.
- mem_rdata  input  32  refill word; beats arrive in ascending word order.
- hit_count  output  32  performance counter (see Optional Feature).
- miss_count  output  32  performance counter (see Optional Feature).

Behaviour:
- Address split:
  - offset = addr[1:0], ignored.
  - word = next log2(WORDS_PER_LINE) bits.
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- Storage:
  - valid[NUM_LINES] flops and a tag array, both reset to 0.
  - Data array is not reset; it is read asynchronously.
- Hit: state LOOKUP and valid[index] and tag match. Then cpu_stall=0 and cpu_instr = data[index][word] in the same cycle (0 extra cycles of latency).
- FSM states: LOOKUP, REQ, FILL, INSTALL.
  - LOOKUP:
    - On miss, cpu_stall=1 combinationally.
    - Latch the line base address (word bits zeroed); fill_cnt=0; go to REQ.
  - REQ:
    - mem_req=1 and mem_addr = latched base, both held stable until mem_ack.
    - mem_ack seen on a rising edge → go to FILL; mem_req drops the next cycle.
  - FILL:
    - Each mem_rvalid writes mem_rdata to data[latched index][fill_cnt], then fill_cnt++.
    - On the beat where fill_cnt = WORDS_PER_LINE-1, go to INSTALL.
    - Gaps between beats are permitted.
  - INSTALL:
    - Write the tag and set valid[latched index]=1; go to LOOKUP.
    - The next cycle re-evaluates cpu_addr.
  - cpu_stall=1 in REQ, FILL and INSTALL.
- Minimum miss penalty: 1 (REQ) + WORDS_PER_LINE beats + 1 (INSTALL) cycles, given zero-wait ack and rvalid.
- cpu_addr changes mid-refill (branch redirect from EX):
  - The refill completes and installs the originally latched line; it is never cancelled.
  - LOOKUP then re-checks the new address. It may hit, or start a new miss.
- invalidate:
  - In LOOKUP: all valid bits clear on the next edge. cpu_stall that cycle reflects the pre-clear state.
  - In REQ/FILL/INSTALL: held pending and applied after INSTALL, i.e. the just-filled line is also invalidated.
  - Pending flag resets to 0.
- mem_rvalid outside FILL is ignored. mem_ack outside REQ is ignored.
- Reset, including mid-refill:
  - FSM → LOOKUP, all valid bits=0, mem_req=0, fill_cnt=0, pending-invalidate=0, counters=0.
  - cpu_stall is then 1 for any address (cold cache).
  - After reset deasserts, any in-flight backing-memory beats are ignored.
- cpu_instr in any non-hit cycle: data[index][word] read, don't-care.

Optional Feature:
- Macro ICACHE_PERF_COUNTERS_EN.
- Defined:
  - hit_count increments on each clk edge in LOOKUP with a hit.
  - miss_count increments on each LOOKUP→REQ transition.
  - Both are 32-bit, wrap modulo 2^32, and clear only on reset.
- Undefined: hit_count and miss_count are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package icache_pkg holds:
  - the icache_state_t enum (LOOKUP, REQ, FILL, INSTALL);
  - localparam helpers for WORD_BITS, INDEX_BITS and TAG_BITS derived from the parameters.
- One natural sub-module, icache_refill_fsm:
  - owns the state, fill_cnt, latched base, the mem_* handshake and pending-invalidate;
  - emits data/tag write strobes to the parent, which holds the arrays and hit logic.

Test Plan:
- Cold fetch: release reset, cpu_addr=0x0000_0000, backing memory returns 0x00000013, 0x00100093, 0x00200113, 0x00300193 with zero wait.
  - mem_addr=0x0; cpu_stall=1 for 6 cycles.
  - Then addresses 0x0, 0x4, 0x8, 0xC hit with those words and cpu_stall=0.
- Conflict miss: with the line at 0x0 resident, fetch 0x400 (same index at 64×16 B).
  - Refill at mem_addr=0x400 replaces the line.
  - Refetching 0x0 misses again, with miss_count=3 when ICACHE_PERF_COUNTERS_EN is defined.
- Backpressure: mem_ack delayed 3 cycles, one idle cycle between each rvalid beat.
  - mem_req and mem_addr stay stable until ack.
  - Stall lasts 3+1+7+1 cycles; line contents are correct.
- Redirect mid-refill: cpu_addr switches from 0x100 to 0x000 (resident) during FILL.
  - Line 0x100 is still installed; after INSTALL, 0x000 hits in one cycle.
  - A later fetch of 0x100 also hits.
- Invalidate: pulse in LOOKUP → the next fetch of 0x0 misses.
  - Pulse during FILL of 0x200 → after INSTALL, 0x200 still misses.
- Reset mid-refill: assert rst low during the second beat.
  - mem_req=0 and counters=0 immediately.
  - Stray mem_rvalid after release writes nothing; fetching 0x0 issues a fresh request.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {LOOKUP, REQ, FILL, INSTALL} icache_state_t;

    // Geometry of the default build; instances derive their own through the helpers.
    localparam int WORD_BITS  = 2;
    localparam int INDEX_BITS = 6;
    localparam int TAG_BITS   = 32 - 2 - WORD_BITS - INDEX_BITS;

    function automatic int wordBits(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    function automatic int indexBits(input int numLines);
        return $clog2(numLines);
    endfunction

    function automatic int tagBits(input int addrW, input int numLines, input int wordsPerLine);
        return addrW - 2 - $clog2(numLines) - $clog2(wordsPerLine);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss/refill sequencer: latches the missing line, runs the backing-memory
// handshake and emits data/tag/valid strobes to the array owner.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    localparam int WB            = wordBits(WORDS_PER_LINE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss,
    input  logic [ADDR_W-WB-3:0]   lineAddr,
    input  logic                   invalidate,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic                   mem_rvalid,
    output icache_state_t          state,
    output logic [WB-1:0]          fillCnt,
    output logic                   dataWe,
    output logic                   tagWe,
    output logic                   clearValid
);

    localparam logic [WB-1:0] LAST = WB'(WORDS_PER_LINE - 1);

    logic invPend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOOKUP;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            fillCnt  <= '0;
            invPend  <= 1'b0;
        end else begin
            case (state)
                LOOKUP: if (miss) begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= {lineAddr, {(WB+2){1'b0}}};
                    fillCnt  <= '0;
                end
                REQ: if (mem_ack) begin
                    state   <= FILL;
                    mem_req <= 1'b0;
                end
                FILL: if (mem_rvalid) begin
                    fillCnt <= fillCnt + 1'b1;
                    if (fillCnt == LAST) state <= INSTALL;
                end
                INSTALL: state <= LOOKUP;
                default: state <= LOOKUP;
            endcase
            // A fence.i seen mid-refill must also kill the line being installed.
            if (state == INSTALL)
                invPend <= 1'b0;
            else if (invalidate && state != LOOKUP)
                invPend <= 1'b1;
        end
    end

    assign dataWe     = (state == FILL) && mem_rvalid;
    assign tagWe      = (state == INSTALL);
    assign clearValid = ((state == LOOKUP) && invalidate) ||
                        ((state == INSTALL) && (invPend || invalidate));

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with same-cycle hits.
// Optional ICACHE_PERF_COUNTERS_EN adds hit/miss performance counters.
module instr_cache
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    input  logic              invalidate,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int WB     = wordBits(WORDS_PER_LINE);
    localparam int IB     = indexBits(NUM_LINES);
    localparam int TB     = tagBits(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam int IDX_LO = WB + 2;
    localparam int TAG_LO = WB + IB + 2;

    logic [NUM_LINES-1:0] valid;
    logic [TB-1:0]        tagArr  [NUM_LINES];
    logic [31:0]          dataArr [NUM_LINES*WORDS_PER_LINE];

    logic [WB-1:0] word;
    logic [IB-1:0] idx, fillIdx;
    logic [TB-1:0] tag, fillTag;
    logic          lineHit, hit, miss;

    icache_state_t state;
    logic [WB-1:0] fillCnt;
    logic          dataWe, tagWe, clearValid;
    logic          unusedBits;

    assign word    = cpu_addr[IDX_LO-1:2];
    assign idx     = cpu_addr[TAG_LO-1:IDX_LO];
    assign tag     = cpu_addr[ADDR_W-1:TAG_LO];
    assign fillIdx = mem_addr[TAG_LO-1:IDX_LO];
    assign fillTag = mem_addr[ADDR_W-1:TAG_LO];
    assign unusedBits = ^{cpu_addr[1:0], mem_addr[IDX_LO-1:0]};

    assign lineHit   = valid[idx] && (tagArr[idx] == tag);
    assign hit       = (state == LOOKUP) && lineHit;
    assign miss      = (state == LOOKUP) && !lineHit;
    assign cpu_stall = !hit;
    assign cpu_instr = dataArr[{idx, word}];

    icache_refill_fsm #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ADDR_W         (ADDR_W)
    ) uRefill (
        .clk        (clk),
        .rst        (rst),
        .miss       (miss),
        .lineAddr   (cpu_addr[ADDR_W-1:IDX_LO]),
        .invalidate (invalidate),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .state      (state),
        .fillCnt    (fillCnt),
        .dataWe     (dataWe),
        .tagWe      (tagWe),
        .clearValid (clearValid)
    );

    // Clear wins over install so a pending fence.i drops the fresh line too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < NUM_LINES; i++) tagArr[i] <= '0;
        end else begin
            if (tagWe) tagArr[fillIdx] <= fillTag;
            if (clearValid)  valid <= '0;
            else if (tagWe)  valid[fillIdx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (dataWe) dataArr[{fillIdx, fillCnt}] <= mem_rdata;
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit)  hit_count  <= hit_count + 32'd1;
            if (miss) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: cold fill, conflict, backpressure, redirect,
// invalidate and mid-refill reset, with a simple backing-memory driver.
module tb_instr_cache;

`ifdef ICACHE_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst;
    logic [31:0] cpu_addr, cpu_instr, mem_addr, mem_rdata, hit_count, miss_count;
    logic        cpu_stall, invalidate, mem_req, mem_ack, mem_rvalid;

    int checks = 0, failures = 0;
    int expHits = 0, expMiss = 0;

    instr_cache dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_instr  (cpu_instr),
        .cpu_stall  (cpu_stall),
        .invalidate (invalidate),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[31:4] == 28'd0) begin
            case (a[3:2])
                2'd0:    return 32'h0000_0013;
                2'd1:    return 32'h0010_0093;
                2'd2:    return 32'h0020_0113;
                default: return 32'h0030_0193;
            endcase
        end
        return 32'hC0DE_0000 | {16'd0, a[15:0]};
    endfunction

    function automatic logic [31:0] expCnt(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic checkHit(input logic [31:0] a, input logic [31:0] exp);
        cpu_addr = a;
        #1;
        chk("hitStall", 32'(cpu_stall), 0);
        chk("hitInstr", cpu_instr, exp);
        expHits++;
        tick;
    endtask

    task automatic startMiss(input logic [31:0] a);
        cpu_addr = a;
        #1;
        chk("missStall", 32'(cpu_stall), 1);
        expMiss++;
        tick;
    endtask

    // Drives one refill from REQ through INSTALL and counts stalled cycles.
    task automatic serveRefill(input logic [31:0] base, input int ackDly, input int gap,
                               input bit redir, input logic [31:0] redirAddr,
                               input bit inv, output int stallCyc);
        stallCyc = 0;
        for (int i = 0; i <= ackDly; i++) begin
            mem_ack = (i == ackDly);
            #1;
            chk("reqValid", 32'(mem_req), 1);
            chk("reqAddr", mem_addr, base);
            stallCyc += int'(cpu_stall);
            tick;
        end
        mem_ack = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < ((w == 0) ? 0 : gap); g++) begin
                #1;
                stallCyc += int'(cpu_stall);
                tick;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = memWord(base + 32'(4 * w));
            if (w == 1 && redir) cpu_addr = redirAddr;
            invalidate = (w == 1) && inv;
            #1;
            stallCyc += int'(cpu_stall);
            tick;
            mem_rvalid = 1'b0;
            invalidate = 1'b0;
        end
        #1;
        chk("reqDrop", 32'(mem_req), 0);
        stallCyc += int'(cpu_stall);
        tick;
    endtask

    task automatic doRefill(input logic [31:0] base, input int ackDly, input int gap,
                            input bit redir, input logic [31:0] redirAddr,
                            input bit inv, output int stallCyc);
        startMiss(base);
        serveRefill(base, ackDly, gap, redir, redirAddr, inv, stallCyc);
    endtask

    initial begin
        int sc;
        rst = 1'b0; cpu_addr = '0; invalidate = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) tick;

        // Reset state
        #1;
        chk("rstStall", 32'(cpu_stall), 1);
        chk("rstReq", 32'(mem_req), 0);
        chk("rstHits", hit_count, 0);
        chk("rstMiss", miss_count, 0);
        rst = 1'b1;
        tick;

        // Cold fetch: 6 stalled cycles after the miss is detected
        doRefill(32'h0, 0, 0, 1'b0, 32'h0, 1'b0, sc);
        chk("coldStallCycles", 32'(sc), 6);
        checkHit(32'h0, 32'h0000_0013);
        checkHit(32'h4, 32'h0010_0093);
        checkHit(32'h8, 32'h0020_0113);
        checkHit(32'hC, 32'h0030_0193);
        chk("coldHitCnt", hit_count, expCnt(4));
        chk("coldMissCnt", miss_count, expCnt(1));

        // Conflict miss on index 0
        doRefill(32'h400, 0, 0, 1'b0, 32'h0, 1'b0, sc);
        checkHit(32'h400, 32'hC0DE_0400);
        checkHit(32'h40C, 32'hC0DE_040C);
        doRefill(32'h0, 0, 0, 1'b0, 32'h0, 1'b0, sc);
        chk("conflictMissCnt", miss_count, expCnt(3));
        chk("conflictHitCnt", hit_count, expCnt(expHits));
        checkHit(32'h4, 32'h0010_0093);

        // Backpressure: ack after 3 cycles, one idle cycle between beats
        doRefill(32'h10, 3, 1, 1'b0, 32'h0, 1'b0, sc);
        chk("bpStallCycles", 32'(sc), 12);
        checkHit(32'h10, 32'hC0DE_0010);
        checkHit(32'h1C, 32'hC0DE_001C);

        // Redirect mid-fill: 0x100 still installs, 0x000 hits right after
        doRefill(32'h100, 0, 0, 1'b1, 32'h0, 1'b0, sc);
        checkHit(32'h0, 32'h0000_0013);
        checkHit(32'h104, 32'hC0DE_0104);

        // Invalidate in LOOKUP: that cycle still hits, next fetch misses
        cpu_addr = 32'h0;
        invalidate = 1'b1;
        #1;
        chk("invSameCycle", 32'(cpu_stall), 0);
        expHits++;
        tick;
        invalidate = 1'b0;
        doRefill(32'h0, 0, 0, 1'b0, 32'h0, 1'b0, sc);
        checkHit(32'h8, 32'h0020_0113);

        // Invalidate during FILL of 0x200: line is dropped after INSTALL
        doRefill(32'h200, 0, 0, 1'b0, 32'h0, 1'b1, sc);
        doRefill(32'h200, 0, 0, 1'b0, 32'h0, 1'b0, sc);
        checkHit(32'h204, 32'hC0DE_0204);
        chk("invHitCnt", hit_count, expCnt(expHits));
        chk("invMissCnt", miss_count, expCnt(expMiss));

        // Reset during the second refill beat
        startMiss(32'h0);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_0000;
        tick;
        mem_rdata = 32'hDEAD_0001;
        rst = 1'b0;
        #1;
        chk("midRstReq", 32'(mem_req), 0);
        chk("midRstHits", hit_count, 0);
        chk("midRstMiss", miss_count, 0);
        chk("midRstStall", 32'(cpu_stall), 1);
        expHits = 0;
        expMiss = 0;
        tick;
        tick;
        rst = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        startMiss(32'h0);
        #1;
        chk("freshReq", 32'(mem_req), 1);
        chk("freshAddr", mem_addr, 32'h0);
        tick;
        mem_rvalid = 1'b0;
        serveRefill(32'h0, 0, 0, 1'b0, 32'h0, 1'b0, sc);
        chk("freshStallCycles", 32'(sc), 6);
        checkHit(32'h0, 32'h0000_0013);
        checkHit(32'h4, 32'h0010_0093);
        chk("postRstMissCnt", miss_count, expCnt(1));
        chk("postRstHitCnt", hit_count, expCnt(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
